// File: rtl/axi_mon_pkg.sv
// Shared definitions for the passive AXI4 channel monitor: error bit map and statistic codes.
package axi_mon_pkg;

  localparam int unsigned ERR_W = 13;

  // err_vec bit positions; bits 0..3 follow the AW/W/AR/R channel order
  localparam int unsigned ErrAwDrop       = 0;
  localparam int unsigned ErrWDrop        = 1;
  localparam int unsigned ErrArDrop       = 2;
  localparam int unsigned ErrRDrop        = 3;
  localparam int unsigned ErrAwAddr       = 4;
  localparam int unsigned ErrArAddr       = 5;
  localparam int unsigned ErrWLen         = 6;
  localparam int unsigned ErrRLen         = 7;
  localparam int unsigned ErrStallTimeout = 8;
  localparam int unsigned ErrOverflow     = 9;
  localparam int unsigned ErrBNoOut       = 10;
  localparam int unsigned ErrRNoOut       = 11;
  localparam int unsigned ErrWNoLen       = 12;

  typedef enum logic [3:0] {
    StatAwXfer  = 4'd0,
    StatWXfer   = 4'd1,
    StatBXfer   = 4'd2,
    StatArXfer  = 4'd3,
    StatRXfer   = 4'd4,
    StatAwStall = 4'd5,
    StatWStall  = 4'd6,
    StatArStall = 4'd7,
    StatRStall  = 4'd8,
    StatMaxRun  = 4'd9,
    StatWrOut   = 4'd10,
    StatRdOut   = 4'd11
  } stat_sel_e;

endpackage

// File: rtl/axi_mon_len_fifo.sv
// Burst-length FIFO (8-bit entries); a push while full is dropped unless a pop frees the slot.
module axi_mon_len_fifo #(
  parameter int unsigned Depth = 16  // power of two, >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]      mem_q [Depth];
  logic            do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= din;
  end

endmodule

// File: rtl/axi_channel_monitor.sv
// Passive AXI4 monitor: saturating statistics, burst tracking and sticky protocol errors.
// Define AXI_MON_LOG_EN for a simulation-only transfer/error trace.
module axi_channel_monitor
  import axi_mon_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH       = 32,
  parameter int unsigned STALL_TIMEOUT   = 256,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      aw_valid,
  input  logic                      aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
  input  logic [7:0]                aw_len,
  input  logic                      w_valid,
  input  logic                      w_ready,
  input  logic                      w_last,
  input  logic                      b_valid,
  input  logic                      b_ready,
  input  logic                      ar_valid,
  input  logic                      ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
  input  logic [7:0]                ar_len,
  input  logic                      r_valid,
  input  logic                      r_ready,
  input  logic                      r_last,
  input  logic                      clear_stats,
  input  logic [3:0]                stat_sel,
  output logic [CNT_WIDTH-1:0]      stat_data,
  output logic [ERR_W-1:0]          err_vec,
  output logic                      err_any
);

  localparam int unsigned NumXfer  = 5;
  localparam int unsigned NumStall = 4;

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t CntMax  = '1;
  localparam cnt_t CntOne  = cnt_t'(1);
  localparam cnt_t Timeout = cnt_t'(STALL_TIMEOUT);

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire, w_last_fire, r_last_fire;
  logic [NumXfer-1:0]  xfer_fire;
  logic [NumStall-1:0] ch_valid, ch_ready, ch_stall;

  assign aw_fire     = aw_valid & aw_ready;
  assign w_fire      = w_valid & w_ready;
  assign b_fire      = b_valid & b_ready;
  assign ar_fire     = ar_valid & ar_ready;
  assign r_fire      = r_valid & r_ready;
  assign w_last_fire = w_fire & w_last;
  assign r_last_fire = r_fire & r_last;
  assign xfer_fire   = {r_fire, ar_fire, b_fire, w_fire, aw_fire};
  assign ch_valid    = {r_valid, ar_valid, w_valid, aw_valid};
  assign ch_ready    = {r_ready, ar_ready, w_ready, aw_ready};
  assign ch_stall    = ch_valid & ~ch_ready;

  logic [NumXfer-1:0][CNT_WIDTH-1:0]  xfer_q, xfer_d;
  logic [NumStall-1:0][CNT_WIDTH-1:0] stall_q, stall_d, run_q, run_d;
  cnt_t                               max_q, max_d, wr_out_q, wr_out_d, rd_out_q, rd_out_d;
  logic [8:0]                         w_beat_q, w_beat_d, r_beat_q, r_beat_d;
  logic [NumStall-1:0]                stall_prev_q;
  logic [AXI_ADDR_WIDTH-1:0]          aw_addr_q, ar_addr_q;
  logic [ERR_W-1:0]                   err_q, err_d, err_set;
  cnt_t                               stat_q, stat_d;
  logic                               err_any_q;

  // Length FIFOs; an AW/AR arriving with the closing xLAST on an empty FIFO bypasses it
  logic       aw_push, aw_pop, aw_full, aw_empty, aw_bypass;
  logic       ar_push, ar_pop, ar_full, ar_empty, ar_bypass;
  logic [7:0] aw_head, ar_head, w_len, r_len;

  assign aw_bypass = w_last_fire & aw_empty & aw_fire;
  assign aw_pop    = w_last_fire & ~aw_empty;
  assign aw_push   = aw_fire & ~aw_bypass;
  assign ar_bypass = r_last_fire & ar_empty & ar_fire;
  assign ar_pop    = r_last_fire & ~ar_empty;
  assign ar_push   = ar_fire & ~ar_bypass;
  assign w_len     = aw_empty ? aw_len : aw_head;
  assign r_len     = ar_empty ? ar_len : ar_head;

  axi_mon_len_fifo #(
    .Depth (MAX_OUTSTANDING)
  ) u_aw_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (aw_push),
    .pop   (aw_pop),
    .din   (aw_len),
    .full  (aw_full),
    .empty (aw_empty),
    .head  (aw_head)
  );

  axi_mon_len_fifo #(
    .Depth (MAX_OUTSTANDING)
  ) u_ar_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ar_push),
    .pop   (ar_pop),
    .din   (ar_len),
    .full  (ar_full),
    .empty (ar_empty),
    .head  (ar_head)
  );

  always_comb begin
    err_set = '0;
    max_d   = max_q;
    for (int i = 0; i < NumXfer; i++) begin
      xfer_d[i] = (xfer_fire[i] && xfer_q[i] != CntMax) ? xfer_q[i] + CntOne : xfer_q[i];
    end
    for (int i = 0; i < NumStall; i++) begin
      stall_d[i] = (ch_stall[i] && stall_q[i] != CntMax) ? stall_q[i] + CntOne : stall_q[i];
      if (ch_stall[i]) begin
        run_d[i] = (run_q[i] != CntMax) ? run_q[i] + CntOne : run_q[i];
      end else begin
        run_d[i] = '0;
      end
      if (run_d[i] > max_d) max_d = run_d[i];
      if (ch_stall[i] && run_d[i] == Timeout) err_set[ErrStallTimeout] = 1'b1;
      if (stall_prev_q[i] && !ch_valid[i]) err_set[i] = 1'b1;
    end
    err_set[ErrAwAddr] = stall_prev_q[0] & aw_valid & (aw_addr != aw_addr_q);
    err_set[ErrArAddr] = stall_prev_q[2] & ar_valid & (ar_addr != ar_addr_q);

    // Beat counters hold beats-1 at the closing beat, matching AxLEN encoding
    w_beat_d = w_beat_q;
    if (w_last_fire)                       w_beat_d = '0;
    else if (w_fire && w_beat_q != '1)     w_beat_d = w_beat_q + 9'd1;
    r_beat_d = r_beat_q;
    if (r_last_fire)                       r_beat_d = '0;
    else if (r_fire && r_beat_q != '1)     r_beat_d = r_beat_q + 9'd1;

    err_set[ErrWLen]     = (aw_pop | aw_bypass) & (w_beat_q != {1'b0, w_len});
    err_set[ErrRLen]     = (ar_pop | ar_bypass) & (r_beat_q != {1'b0, r_len});
    err_set[ErrWNoLen]   = w_last_fire & ~aw_pop & ~aw_bypass;
    err_set[ErrOverflow] = (aw_push & aw_full & ~aw_pop) | (ar_push & ar_full & ~ar_pop);
    err_set[ErrBNoOut]   = b_fire & (wr_out_q == '0);
    err_set[ErrRNoOut]   = r_last_fire & (rd_out_q == '0);

    wr_out_d = wr_out_q;
    if (aw_fire && !b_fire) begin
      if (wr_out_q != CntMax) wr_out_d = wr_out_q + CntOne;
    end else if (b_fire && !aw_fire && wr_out_q != '0) begin
      wr_out_d = wr_out_q - CntOne;
    end
    rd_out_d = rd_out_q;
    if (ar_fire && !r_last_fire) begin
      if (rd_out_q != CntMax) rd_out_d = rd_out_q + CntOne;
    end else if (r_last_fire && !ar_fire && rd_out_q != '0) begin
      rd_out_d = rd_out_q - CntOne;
    end

    err_d = err_q | err_set;

    // Clear wins over same-cycle increments; tracking state is left intact
    if (clear_stats) begin
      xfer_d  = '0;
      stall_d = '0;
      max_d   = '0;
      err_d   = '0;
    end

    case (stat_sel)
      StatAwXfer:  stat_d = xfer_q[0];
      StatWXfer:   stat_d = xfer_q[1];
      StatBXfer:   stat_d = xfer_q[2];
      StatArXfer:  stat_d = xfer_q[3];
      StatRXfer:   stat_d = xfer_q[4];
      StatAwStall: stat_d = stall_q[0];
      StatWStall:  stat_d = stall_q[1];
      StatArStall: stat_d = stall_q[2];
      StatRStall:  stat_d = stall_q[3];
      StatMaxRun:  stat_d = max_q;
      StatWrOut:   stat_d = wr_out_q;
      StatRdOut:   stat_d = rd_out_q;
      default:     stat_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_q       <= '0;
      stall_q      <= '0;
      run_q        <= '0;
      max_q        <= '0;
      wr_out_q     <= '0;
      rd_out_q     <= '0;
      w_beat_q     <= '0;
      r_beat_q     <= '0;
      stall_prev_q <= '0;
      aw_addr_q    <= '0;
      ar_addr_q    <= '0;
      err_q        <= '0;
      stat_q       <= '0;
      err_any_q    <= 1'b0;
    end else begin
      xfer_q       <= xfer_d;
      stall_q      <= stall_d;
      run_q        <= run_d;
      max_q        <= max_d;
      wr_out_q     <= wr_out_d;
      rd_out_q     <= rd_out_d;
      w_beat_q     <= w_beat_d;
      r_beat_q     <= r_beat_d;
      stall_prev_q <= ch_stall;
      aw_addr_q    <= aw_addr;
      ar_addr_q    <= ar_addr;
      err_q        <= err_d;
      stat_q       <= stat_d;
      err_any_q    <= |err_q;
    end
  end

  assign stat_data = stat_q;
  assign err_vec   = err_q;
  assign err_any   = err_any_q;

`ifdef AXI_MON_LOG_EN
  function automatic string chan_name(int idx);
    case (idx)
      0:       return "AW";
      1:       return "W";
      2:       return "AR";
      default: return "R";
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      if (aw_fire) $display("%0t axi_mon AW addr=%h len=%0d", $time, aw_addr, aw_len);
      if (w_fire)  $display("%0t axi_mon W last=%0b", $time, w_last);
      if (b_fire)  $display("%0t axi_mon B", $time);
      if (ar_fire) $display("%0t axi_mon AR addr=%h len=%0d", $time, ar_addr, ar_len);
      if (r_fire)  $display("%0t axi_mon R last=%0b", $time, r_last);
      for (int i = 0; i < NumStall; i++) begin
        if (ch_stall[i] && run_d[i] == Timeout)
          $display("%0t axi_mon %s stall timeout", $time, chan_name(i));
      end
      for (int i = 0; i < ERR_W; i++) begin
        if (err_set[i] && !err_q[i] && !clear_stats)
          $display("%0t axi_mon err_vec[%0d] raised", $time, i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_channel_monitor.sv
// Directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_axi_channel_monitor;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 32;
  localparam int unsigned TO = 256;
  localparam int unsigned MO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          aw_valid = 0, aw_ready = 0, w_valid = 0, w_ready = 0, w_last = 0;
  logic          b_valid = 0, b_ready = 0, ar_valid = 0, ar_ready = 0;
  logic          r_valid = 0, r_ready = 0, r_last = 0, clear_stats = 0;
  logic [AW-1:0] aw_addr = '0, ar_addr = '0;
  logic [7:0]    aw_len = '0, ar_len = '0;
  logic [3:0]    stat_sel = '0;
  logic [CW-1:0] stat_data;
  logic [12:0]   err_vec;
  logic          err_any;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_channel_monitor #(
    .AXI_ADDR_WIDTH  (AW),
    .CNT_WIDTH       (CW),
    .STALL_TIMEOUT   (TO),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .aw_valid    (aw_valid),
    .aw_ready    (aw_ready),
    .aw_addr     (aw_addr),
    .aw_len      (aw_len),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_last      (w_last),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .ar_valid    (ar_valid),
    .ar_ready    (ar_ready),
    .ar_addr     (ar_addr),
    .ar_len      (ar_len),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .r_last      (r_last),
    .clear_stats (clear_stats),
    .stat_sel    (stat_sel),
    .stat_data   (stat_data),
    .err_vec     (err_vec),
    .err_any     (err_any)
  );

  // Reference model: per-edge bookkeeping from the monitor's rules
  longint      m_xfer [5];
  longint      m_stall [4];
  longint      m_run [4];
  longint      m_max, m_wr_out, m_rd_out;
  int          m_wbeats, m_rbeats;
  int unsigned m_awq [$];
  int unsigned m_arq [$];
  bit          m_prev_stall [4];
  logic [AW-1:0] m_prev_awaddr, m_prev_araddr;
  logic [12:0] m_err;
  logic [31:0] exp_stat;
  logic        exp_err_any;

  function automatic logic [31:0] model_stat(input logic [3:0] sel);
    if (sel <= 4)       return 32'(m_xfer[sel]);
    else if (sel <= 8)  return 32'(m_stall[sel-5]);
    else if (sel == 9)  return 32'(m_max);
    else if (sel == 10) return 32'(m_wr_out);
    else if (sel == 11) return 32'(m_rd_out);
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 5; c++) m_xfer[c] = 0;
    for (int c = 0; c < 4; c++) begin
      m_stall[c] = 0; m_run[c] = 0; m_prev_stall[c] = 0;
    end
    m_max = 0; m_wr_out = 0; m_rd_out = 0; m_wbeats = 0; m_rbeats = 0;
    m_awq.delete(); m_arq.delete();
    m_prev_awaddr = '0; m_prev_araddr = '0;
    m_err = '0; exp_stat = '0; exp_err_any = 1'b0;
  endtask

  task automatic model_step();
    bit v [4];
    bit r [4];
    bit awf, wf, bf, arf, rf, bypass;
    logic [12:0] e;
    int unsigned len;
    if (!rst_n) begin
      model_reset();
      return;
    end
    exp_stat    = model_stat(stat_sel);
    exp_err_any = |m_err;
    e = '0;
    v = '{aw_valid, w_valid, ar_valid, r_valid};
    r = '{aw_ready, w_ready, ar_ready, r_ready};
    awf = aw_valid && aw_ready; wf = w_valid && w_ready; bf = b_valid && b_ready;
    arf = ar_valid && ar_ready; rf = r_valid && r_ready;
    if (m_prev_stall[0] && aw_valid && aw_addr != m_prev_awaddr) e[4] = 1;
    if (m_prev_stall[2] && ar_valid && ar_addr != m_prev_araddr) e[5] = 1;
    m_prev_awaddr = aw_addr;
    m_prev_araddr = ar_addr;
    for (int c = 0; c < 4; c++) begin
      if (m_prev_stall[c] && !v[c]) e[c] = 1;
      if (v[c] && !r[c]) begin
        m_run[c]++;
        m_stall[c]++;
        if (m_run[c] == TO) e[8] = 1;
      end else begin
        m_run[c] = 0;
      end
      if (m_run[c] > m_max) m_max = m_run[c];
      m_prev_stall[c] = v[c] && !r[c];
    end
    m_xfer[0] += awf; m_xfer[1] += wf; m_xfer[2] += bf; m_xfer[3] += arf; m_xfer[4] += rf;
    // write side
    bypass = 0;
    if (wf && w_last) begin
      if (m_awq.size() > 0) begin
        len = m_awq.pop_front();
        if (m_wbeats != len) e[6] = 1;
      end else if (awf) begin
        bypass = 1;
        if (m_wbeats != aw_len) e[6] = 1;
      end else begin
        e[12] = 1;
      end
      m_wbeats = 0;
    end else if (wf) begin
      m_wbeats++;
    end
    if (awf && !bypass) begin
      if (m_awq.size() < MO) m_awq.push_back(aw_len);
      else e[9] = 1;
    end
    // read side
    bypass = 0;
    if (rf && r_last) begin
      if (m_arq.size() > 0) begin
        len = m_arq.pop_front();
        if (m_rbeats != len) e[7] = 1;
      end else if (arf) begin
        bypass = 1;
        if (m_rbeats != ar_len) e[7] = 1;
      end
      m_rbeats = 0;
    end else if (rf) begin
      m_rbeats++;
    end
    if (arf && !bypass) begin
      if (m_arq.size() < MO) m_arq.push_back(ar_len);
      else e[9] = 1;
    end
    // outstanding bursts
    if (bf && m_wr_out == 0) e[10] = 1;
    if (awf && !bf) m_wr_out++;
    else if (bf && !awf && m_wr_out > 0) m_wr_out--;
    if (rf && r_last && m_rd_out == 0) e[11] = 1;
    if (arf && !(rf && r_last)) m_rd_out++;
    else if (rf && r_last && !arf && m_rd_out > 0) m_rd_out--;
    if (clear_stats) begin
      for (int c = 0; c < 5; c++) m_xfer[c] = 0;
      for (int c = 0; c < 4; c++) m_stall[c] = 0;
      m_max = 0;
      m_err = '0;
    end else begin
      m_err = m_err | e;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    aw_valid = 0; aw_ready = 0; w_valid = 0; w_ready = 0; w_last = 0;
    b_valid = 0; b_ready = 0; ar_valid = 0; ar_ready = 0;
    r_valid = 0; r_ready = 0; r_last = 0; clear_stats = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic rd(input logic [3:0] sel, input logic [31:0] exp, input string tag);
    stat_sel = sel;
    tick();
    check(tag, stat_data, exp);
  endtask

  task automatic aw_beat(input logic [7:0] len);
    aw_valid = 1; aw_ready = 1; aw_len = len;
    tick();
    idle();
  endtask

  task automatic w_burst(input int beats);
    for (int i = 0; i < beats; i++) begin
      w_valid = 1; w_ready = 1; w_last = (i == beats - 1);
      tick();
    end
    idle();
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_err_vec", 32'(err_vec), 0);
    check("rst_err_any", 32'(err_any), 0);
    check("rst_stat", stat_data, 0);

    // clean write burst: len=3, four beats, then B
    aw_addr = 32'h100;
    aw_beat(8'd3);
    w_burst(4);
    b_valid = 1; b_ready = 1; tick(); idle();
    rd(4'd0, 1, "wr_aw_xfer");
    rd(4'd1, 4, "wr_w_xfer");
    rd(4'd2, 1, "wr_b_xfer");
    rd(4'd10, 0, "wr_outstanding");
    check("wr_err_vec", 32'(err_vec), 0);

    // read burst len=1 closed on beat 3
    do_reset();
    ar_valid = 1; ar_ready = 1; ar_len = 8'd1; tick(); idle();
    r_valid = 1; r_ready = 1; tick(); tick();
    r_last = 1; tick(); idle();
    check("rlen_err_vec", 32'(err_vec), 32'h080);
    check("rlen_err_any_lag", 32'(err_any), 0);
    tick();
    check("rlen_err_any", 32'(err_any), 1);
    rd(4'd11, 0, "rlen_rd_out");

    // AR stall timeout with address change mid-stall
    do_reset();
    ar_valid = 1; ar_ready = 0; ar_addr = 32'hA000;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) ar_addr = 32'hB000;
      tick();
    end
    check("stall_err_vec", 32'(err_vec), 32'h120);
    stat_sel = 4'd7; ar_ready = 1; tick();
    check("stall_ar_total", stat_data, 256);
    idle();
    rd(4'd9, 256, "stall_max_run");

    // AW FIFO overflow
    do_reset();
    aw_valid = 1; aw_ready = 1; aw_len = 8'd0;
    for (int i = 0; i < 17; i++) tick();
    idle();
    check("ovf_err_vec", 32'(err_vec), 32'h200);
    rd(4'd10, 17, "ovf_wr_out");
    do_reset();
    b_valid = 1; b_ready = 1; tick(); idle();
    check("b_noout_err_vec", 32'(err_vec), 32'h400);
    rd(4'd10, 0, "b_noout_wr_out");

    // same-cycle AW and single-beat W on empty FIFO, then an orphan w_last
    do_reset();
    aw_valid = 1; aw_ready = 1; aw_len = 8'd0;
    w_valid = 1; w_ready = 1; w_last = 1;
    tick(); idle();
    check("bypass_err_vec", 32'(err_vec), 0);
    rd(4'd10, 1, "bypass_wr_out");
    w_burst(1);
    check("nolen_err_vec", 32'(err_vec), 32'h1000);

    // clear_stats during a W transfer
    do_reset();
    b_valid = 1; b_ready = 1; tick(); idle();
    aw_beat(8'd1);
    w_valid = 1; w_ready = 1; clear_stats = 1; tick(); idle();
    check("clr_err_vec", 32'(err_vec), 0);
    rd(4'd0, 0, "clr_aw_xfer");
    rd(4'd1, 0, "clr_w_xfer");
    rd(4'd2, 0, "clr_b_xfer");
    rd(4'd10, 1, "clr_wr_out");
    w_burst(1);
    check("clr_burst_done", 32'(err_vec), 0);

    // reset mid-burst, then a clean burst
    aw_beat(8'd3);
    w_valid = 1; w_ready = 1; tick(); tick(); idle();
    do_reset();
    check("midrst_err_vec", 32'(err_vec), 0);
    rd(4'd0, 0, "midrst_aw_xfer");
    rd(4'd10, 0, "midrst_wr_out");
    aw_beat(8'd1);
    w_burst(2);
    b_valid = 1; b_ready = 1; tick(); idle();
    check("post_rst_err_vec", 32'(err_vec), 0);
    rd(4'd1, 2, "post_rst_w_xfer");
    rd(4'd10, 0, "post_rst_wr_out");

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n = (n % 300 != 0);
      aw_valid = (aw_valid && !aw_ready) ? ($urandom_range(9) != 0) : ($urandom_range(1) == 1);
      w_valid  = (w_valid && !w_ready)   ? ($urandom_range(9) != 0) : ($urandom_range(1) == 1);
      ar_valid = (ar_valid && !ar_ready) ? ($urandom_range(9) != 0) : ($urandom_range(1) == 1);
      r_valid  = (r_valid && !r_ready)   ? ($urandom_range(9) != 0) : ($urandom_range(1) == 1);
      if ($urandom_range(9) == 0) aw_addr = 32'($urandom_range(3));
      if ($urandom_range(9) == 0) ar_addr = 32'($urandom_range(3));
      aw_ready = $urandom_range(1); w_ready = $urandom_range(1);
      ar_ready = $urandom_range(1); r_ready = $urandom_range(1);
      b_valid  = ($urandom_range(2) == 0); b_ready = $urandom_range(1);
      aw_len   = 8'($urandom_range(2)); ar_len = 8'($urandom_range(2));
      w_last   = ($urandom_range(2) == 0); r_last = ($urandom_range(2) == 0);
      stat_sel = 4'($urandom_range(15));
      tick();
      check("rnd_err_vec", 32'(err_vec), 32'(m_err));
      check("rnd_err_any", 32'(err_any), 32'(exp_err_any));
      check("rnd_stat", stat_data, exp_stat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
